// File: rtl/dp_ram_pkg.sv
// Shared constants and clear-sequencer state encoding for the parametrised dual-port RAM.
package dp_ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StReady = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dp_ram_clear_fsm.sv
// Post-reset clear sequencer: zeroes every word once, then hands the write port to the user.
module dp_ram_clear_fsm
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [NUM_LANES-1:0] wr_be,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [NUM_LANES-1:0] mem_be,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 init_busy
);

    clr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = wr_en;
        mem_addr   = wr_addr;
        mem_be     = wr_be;
        mem_data   = wr_data;
        init_busy  = 1'b0;
        unique case (state_q)
            StClear: begin
                // User requests are dropped while the array is being zeroed
                init_busy  = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = clr_addr_q;
                mem_be     = '1;
                mem_data   = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = StReady;
                end
            end
            StReady: begin
            end
            default: state_d = StClear;
        endcase
    end

endmodule

// File: rtl/dp_ram_param.sv
// Simple dual-port RAM with byte-lane writes, selectable read-during-write behaviour,
// optional output register, response qualifier, collision flag and post-reset clear.
module dp_ram_param
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned LANE_W   = 4,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/LANE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       collision,
    output logic                       init_busy
);

    localparam int unsigned NUM_LANES = DATA_W / LANE_W;
    localparam int unsigned DEPTH     = 2 ** ADDR_W;

    if (DATA_W % LANE_W != 0) begin : g_width_check
        $error("dp_ram_param: DATA_W must be a multiple of LANE_W");
    end

    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [NUM_LANES-1:0] mem_be;
    logic [DATA_W-1:0]    mem_data;

    dp_ram_clear_fsm #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_LANES (NUM_LANES)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_data  (mem_data),
        .init_busy (init_busy)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][i*LANE_W +: LANE_W] <= mem_data[i*LANE_W +: LANE_W];
            end
        end
    end

    logic              rd_fire, wr_fire, coll;
    logic [DATA_W-1:0] rd_old, rd_new, rd_word;

    assign rd_fire = rd_en & ~init_busy;
    assign wr_fire = wr_en & ~init_busy;
    assign coll    = rd_fire & wr_fire & (rd_addr == wr_addr);
    assign rd_old  = mem[rd_addr];

    // Word as it will look after this cycle's write lands
    always_comb begin
        rd_new = rd_old;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_be[i]) begin
                rd_new[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_word = (RDW_MODE == RDW_NEW && coll) ? rd_new : rd_old;

    logic [DATA_W-1:0] data1_q;
    logic              valid1_q, coll1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q  <= '0;
            valid1_q <= 1'b0;
            coll1_q  <= 1'b0;
        end else begin
            valid1_q <= rd_fire;
            coll1_q  <= coll;
            if (rd_fire) begin
                data1_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] data2_q;
        logic              valid2_q, coll2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data2_q  <= '0;
                valid2_q <= 1'b0;
                coll2_q  <= 1'b0;
            end else begin
                valid2_q <= valid1_q;
                coll2_q  <= coll1_q;
                if (valid1_q) begin
                    data2_q <= data1_q;
                end
            end
        end

        assign rd_data   = data2_q;
        assign rd_valid  = valid2_q;
        assign collision = coll2_q;
    end else begin : g_no_out_reg
        assign rd_data   = data1_q;
        assign rd_valid  = valid1_q;
        assign collision = coll1_q;
    end

endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: two instances (old-data/latency-1 and new-data/latency-2) on shared stimulus.
`timescale 1ns/1ps
module tb_dp_ram_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_be = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b, coll_a, coll_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    dp_ram_param #(
        .DATA_W (8), .ADDR_W (4), .LANE_W (4), .RDW_MODE (0), .OUT_REG (0)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be),
        .wr_data (wr_data), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_a),
        .rd_valid (rd_valid_a), .collision (coll_a), .init_busy (busy_a)
    );

    dp_ram_param #(
        .DATA_W (8), .ADDR_W (4), .LANE_W (4), .RDW_MODE (1), .OUT_REG (1)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_addr (wr_addr), .wr_be (wr_be),
        .wr_data (wr_data), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_b),
        .rd_valid (rd_valid_b), .collision (coll_b), .init_busy (busy_b)
    );

    // Reference model: word array, busy countdown, expected response per instance
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
    } resp_t;

    logic [7:0] mm [16];
    int         busy_left;
    resp_t      a_exp, b_pipe, b_exp;

    function automatic logic [7:0] merge(logic [7:0] old, logic [1:0] be, logic [7:0] data);
        logic [7:0] res = old;
        for (int l = 0; l < 2; l++) begin
            if (be[l]) res[l*4 +: 4] = data[l*4 +: 4];
        end
        return res;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mm[i] = 8'h00;
        busy_left = 16;
        a_exp  = '{v: 1'b0, d: 8'h00, c: 1'b0};
        b_pipe = '{v: 1'b0, d: 8'h00, c: 1'b0};
        b_exp  = '{v: 1'b0, d: 8'h00, c: 1'b0};
    endtask

    task automatic model_edge();
        bit         busy = (busy_left > 0);
        logic       v = rd_en && !busy;
        logic       c = v && wr_en && (wr_addr == rd_addr);
        logic [7:0] old_w = mm[rd_addr];
        logic [7:0] new_w = c ? merge(old_w, wr_be, wr_data) : old_w;
        resp_t      a_nx, b_nx, bp_nx;
        a_nx  = '{v: v, d: v ? old_w : a_exp.d, c: c};
        b_nx  = '{v: b_pipe.v, d: b_pipe.v ? b_pipe.d : b_exp.d, c: b_pipe.c};
        bp_nx = '{v: v, d: v ? new_w : b_pipe.d, c: c};
        if (wr_en && !busy) mm[wr_addr] = merge(mm[wr_addr], wr_be, wr_data);
        if (busy_left > 0) busy_left--;
        a_exp  = a_nx;
        b_exp  = b_nx;
        b_pipe = bp_nx;
    endtask

    task automatic check_outputs();
        logic exp_busy = (busy_left > 0);
        chk("busy_a",  32'(busy_a),     32'(exp_busy));
        chk("busy_b",  32'(busy_b),     32'(exp_busy));
        chk("valid_a", 32'(rd_valid_a), 32'(a_exp.v));
        chk("coll_a",  32'(coll_a),     32'(a_exp.c));
        chk("data_a",  32'(rd_data_a),  32'(a_exp.d));
        chk("valid_b", 32'(rd_valid_b), 32'(b_exp.v));
        chk("coll_b",  32'(coll_b),     32'(b_exp.c));
        chk("data_b",  32'(rd_data_b),  32'(b_exp.d));
    endtask

    // One clock: check current outputs at the falling edge, drive the next request, advance model
    task automatic cycle(logic we, logic [3:0] wa, logic [1:0] be, logic [7:0] wd,
                         logic re, logic [3:0] ra);
        @(negedge clk);
        check_outputs();
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
        chk("rst_coll_a",  32'(coll_a),     32'd0);
        chk("rst_data_a",  32'(rd_data_a),  32'd0);
        chk("rst_data_b",  32'(rd_data_b),  32'd0);
        chk("rst_busy_a",  32'(busy_a),     32'd1);
        model_reset();
        #9;
        rst_n = 1'b1;
        model_edge();
    endtask

    task automatic measure_clear(string name);
        int n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            cycle(1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 4'd0);
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [1:0] be;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic       ev;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        // Expectations for the old-data, latency-1 instance
        tbl[0]  = '{1'b1, 4'd0, 2'b11, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 4'd1, 2'b11, 8'h01, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 4'd2, 2'b11, 8'h02, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd0, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd1, 1'b1, 8'h01, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd2, 1'b1, 8'h02, 1'b0};
        tbl[6]  = '{1'b1, 4'd3, 2'b11, 8'hAA, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 4'd3, 2'b01, 8'h5F, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hAF, 1'b0};
        tbl[9]  = '{1'b1, 4'd3, 2'b00, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hAF, 1'b0};
        tbl[11] = '{1'b1, 4'd1, 2'b11, 8'hAA, 1'b1, 4'd1, 1'b1, 8'h01, 1'b1};
        tbl[12] = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd1, 1'b1, 8'hAA, 1'b0};
        tbl[13] = '{1'b1, 4'd2, 2'b11, 8'h33, 1'b1, 4'd0, 1'b1, 8'h00, 1'b0};
        tbl[14] = '{1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd2, 1'b1, 8'h33, 1'b0};

        // Reset, clear length, all-zero contents
        model_reset();
        do_reset();
        measure_clear("clear_len");
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'(i));

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].re, tbl[i].ra);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid_a), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_coll", i),  32'(coll_a),     32'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(rd_data_a), 32'(tbl[i].ed));
        end

        // Back-to-back reads on both instances, then random traffic
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'(i));
        for (int i = 0; i < 400; i++) begin
            logic [3:0] wa = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                         : 4'($urandom_range(0, 15));
            logic [3:0] ra = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                         : 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ra);
        end

        // Writes during clear are dropped; reset mid-clear restarts the sequence
        do_reset();
        cycle(1'b1, 4'd5, 2'b11, 8'hFF, 1'b1, 4'd5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd5, 2'b11, 8'hFF, 1'b0, 4'd0);
        do_reset();
        measure_clear("clear_len_restart");
        cycle(1'b0, 4'd0, 2'b00, 8'h00, 1'b1, 4'd5);
        @(posedge clk);
        #1;
        chk("addr5_valid", 32'(rd_valid_a), 32'd1);
        chk("addr5_data",  32'(rd_data_a),  32'h00);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 2'b00, 8'h00, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
